bmp_uart_sequencer: RTL and testbench
=====================================

BMP_UART_SEQUENCER -- requirements
Module: bmp_uart_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, image width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 5, image height in pixels.
REQ-003 The block SHALL have parameter BMP_HEADER_NUM, default 54, header byte count.
REQ-004 The block SHALL have one clock, HCLK; reset is asynchronous and active-low, HRESET.
REQ-005 Ports SHALL be:
- HCLK  in  1  clock
- HRESET  in  1  async active-low reset
- start  in  1  level; image buffer ready (write_done)
- mem_rd_en  out  1  pixel memory read strobe
- mem_rd_addr  out  19  pixel byte address, 0..WIDTH*HEIGHT*3-1
- mem_rd_data  in  8  pixel byte, valid the cycle after mem_rd_en
- transmitData  out  8  byte to UART
- TxD_start  out  1  one-cycle launch pulse to UART
- TxD_done  in  1  one-cycle pulse, UART byte complete
- busy  out  1  transfer in progress
- isTransmitted  out  1  whole file sent

Function
REQ-006 The FSM SHALL have states IDLE, HDR, FETCH, RDWAIT, SEND, WAITDONE, DONE.
REQ-007 IDLE: start=1 sampled -> HDR with byte index 0; otherwise stay.
REQ-008 HDR SHALL load transmitData with header byte[index], pulse TxD_start one cycle, and enter WAITDONE.
REQ-009 Header bytes SHALL be generated internally, little-endian: 0-1 = 66,77; 2-5 = BMP_HEADER_NUM+WIDTH*HEIGHT*3; 6-9 = 0; 10-13 = BMP_HEADER_NUM; 14-17 = 40; 18-21 = WIDTH; 22-25 = HEIGHT; 26-27 = 1; 28-29 = 24; 30-53 = 0.
REQ-010 FETCH SHALL assert mem_rd_en=1 for one cycle with mem_rd_addr = index-BMP_HEADER_NUM, then go to RDWAIT.
REQ-011 RDWAIT SHALL go to SEND; SEND SHALL capture mem_rd_data into transmitData, pulse TxD_start, and enter WAITDONE.
REQ-012 WAITDONE SHALL hold transmitData stable and TxD_start=0 until TxD_done=1; on TxD_done the index SHALL increment and the FSM SHALL go to HDR if index<BMP_HEADER_NUM, FETCH if index<BMP_HEADER_NUM+WIDTH*HEIGHT*3, else DONE.
REQ-013 Latency: start sampled at edge N -> TxD_start high after edge N+1; TxD_done at edge M -> next header TxD_start after edge M+1, next pixel TxD_start after edge M+3.
REQ-014 Pixel bytes SHALL be sent in ascending address order; no row padding SHALL be inserted (WIDTH*3 not a multiple of 4 is unsupported).
REQ-015 DONE SHALL hold isTransmitted=1, busy=0; on start=0 -> IDLE with isTransmitted cleared, permitting a resend on the next start=1.
REQ-016 busy SHALL be 1 in every state except IDLE and DONE.
REQ-017 TxD_done SHALL be ignored in every state except WAITDONE; start changes SHALL be ignored outside IDLE and DONE.
REQ-018 The byte index SHALL be 19 bits and SHALL never exceed BMP_HEADER_NUM+WIDTH*HEIGHT*3.
REQ-019 TxD_start SHALL never be high in two consecutive cycles, and exactly one TxD_start SHALL occur per byte.

Reset
REQ-020 HRESET=0 SHALL immediately force IDLE, index=0, TxD_start=0, mem_rd_en=0, mem_rd_addr=0, transmitData=0, busy=0, isTransmitted=0.
REQ-021 Reset mid-transfer SHALL abort with no further TxD_start; after release a new start=1 SHALL restart at header byte 0.

Verification (WIDTH=4, HEIGHT=2, UART model returns TxD_done 10 cycles after each TxD_start, memory byte k = k+100)
REQ-022 start=1 -> 78 TxD_start pulses; bytes 0-5 = 66,77,78,0,0,0; bytes 18,22 = 4,2; bytes 54..77 = 100..123; then isTransmitted=1, busy=0.
REQ-023 Timing: TxD_done for byte 53 at edge M -> mem_rd_en=1, addr 0 after M+1; TxD_start with 100 after M+3.
REQ-024 Spurious TxD_done in IDLE and in RDWAIT -> no index advance, no extra TxD_start.
REQ-025 HRESET asserted after byte 60 launched -> all outputs zero at once; release, start=1 -> byte 0 = 66 resent.
REQ-026 After DONE: start held 1 -> stays DONE; start 0 then 1 -> full 78-byte resend.

Source files
------------

// File: rtl/bmp_uart_sequencer_if.sv
// bmp_uart_sequencer_if: pixel-memory read port and UART byte handshake for the BMP sequencer
interface bmp_uart_sequencer_if;
  logic start;
  logic mem_rd_en;
  logic [18:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] transmitData;
  logic TxD_start;
  logic TxD_done;
  logic busy;
  logic isTransmitted;
  modport master (
    input start, mem_rd_data, TxD_done,
    output mem_rd_en, mem_rd_addr, transmitData, TxD_start, busy, isTransmitted
  );
  modport slave (
    output start, mem_rd_data, TxD_done,
    input mem_rd_en, mem_rd_addr, transmitData, TxD_start, busy, isTransmitted
  );
endinterface

// File: rtl/bmp_uart_sequencer.sv
// bmp_uart_sequencer: streams a generated 24-bit BMP header followed by pixel memory bytes to a UART
module bmp_uart_sequencer #(
  parameter int WIDTH = 10,
  parameter int HEIGHT = 5,
  parameter int BMP_HEADER_NUM = 54
) (
  input logic HCLK,
  input logic HRESET,
  bmp_uart_sequencer_if.master bus
);
  localparam logic [18:0] HDRN = 19'(BMP_HEADER_NUM);
  localparam logic [18:0] LAST = 19'(BMP_HEADER_NUM + WIDTH * HEIGHT * 3);
  localparam logic [31:0] FSIZE = 32'(BMP_HEADER_NUM + WIDTH * HEIGHT * 3);
  typedef enum logic [2:0] {IDLE, HDR, FETCH, RDWAIT, SEND, WAITDONE, DONE} stateT;
  stateT state, stateNext;
  logic [18:0] idx, idxNext, idxInc, addrNext;
  logic [7:0] dataNext, hdrByte;
  logic txNext, rdNext;
  logic [31:0] hdrWord;
  logic [1:0] off;
  // Every header field starts at an offset of 2 mod 4, so one word per field plus a
  // rotated byte lane covers the whole header; the 2-byte fields are pre-shifted to fit.
  assign off = idx[1:0] + 2'd2;
  assign hdrWord = idx < 19'd2  ? 32'h4D42_0000 :
                   idx < 19'd6  ? FSIZE :
                   idx < 19'd10 ? 32'd0 :
                   idx < 19'd14 ? 32'(BMP_HEADER_NUM) :
                   idx < 19'd18 ? 32'd40 :
                   idx < 19'd22 ? 32'(WIDTH) :
                   idx < 19'd26 ? 32'(HEIGHT) :
                   idx < 19'd28 ? 32'd1 :
                   idx < 19'd30 ? 32'h0018_0000 : 32'd0;
  assign hdrByte = 8'(hdrWord >> {off, 3'b000});
  assign idxInc = idx + 19'd1;
  assign bus.busy = state != IDLE && state != DONE;
  assign bus.isTransmitted = state == DONE;
  always_comb begin
    stateNext = state;
    idxNext = idx;
    txNext = 1'b0;
    rdNext = 1'b0;
    dataNext = bus.transmitData;
    addrNext = bus.mem_rd_addr;
    case (state)
      IDLE: if (bus.start) begin
        stateNext = HDR;
        idxNext = '0;
      end
      HDR: begin
        dataNext = hdrByte;
        txNext = 1'b1;
        stateNext = WAITDONE;
      end
      FETCH: begin
        rdNext = 1'b1;
        addrNext = idx - HDRN;
        stateNext = RDWAIT;
      end
      RDWAIT: stateNext = SEND;
      SEND: begin
        dataNext = bus.mem_rd_data;
        txNext = 1'b1;
        stateNext = WAITDONE;
      end
      WAITDONE: if (bus.TxD_done) begin
        idxNext = idxInc;
        stateNext = idxInc < HDRN ? HDR : idxInc < LAST ? FETCH : DONE;
      end
      DONE: if (!bus.start) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state <= IDLE;
      idx <= '0;
      bus.TxD_start <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_rd_addr <= '0;
      bus.transmitData <= '0;
    end else begin
      state <= stateNext;
      idx <= idxNext;
      bus.TxD_start <= txNext;
      bus.mem_rd_en <= rdNext;
      bus.mem_rd_addr <= addrNext;
      bus.transmitData <= dataNext;
    end
  end
endmodule

// File: tb/tb_bmp_uart_sequencer.sv
// tb_bmp_uart_sequencer: directed run of the BMP sequencer against a UART and memory model with a byte scoreboard
module tb_bmp_uart_sequencer;
  localparam int W = 4;
  localparam int H = 2;
  localparam int NB = 54 + W * H * 3;
  logic HCLK = 1'b0;
  logic HRESET = 1'b0;
  logic spurDone = 1'b0;
  logic uartDone = 1'b0;
  logic prevTx = 1'b0;
  logic rdEnS;
  logic [18:0] addrS;
  int cnt = 0;
  int nLaunch = 0;
  int total = 0;
  int bad = 0;
  int base;
  logic [7:0] q[$];
  bmp_uart_sequencer_if bus ();
  bmp_uart_sequencer #(.WIDTH(W), .HEIGHT(H), .BMP_HEADER_NUM(54)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .bus(bus.master)
  );
  always #5 HCLK = ~HCLK;
  assign bus.TxD_done = uartDone | spurDone;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] expByte(input int k);
    int v;
    v = 0;
    if (k >= 54) return 8'(k - 54 + 100);
    if (k == 0) v = 66;
    else if (k == 1) v = 77;
    else if (k >= 2 && k < 6) v = NB >> (8 * (k - 2));
    else if (k >= 10 && k < 14) v = 54 >> (8 * (k - 10));
    else if (k >= 14 && k < 18) v = 40 >> (8 * (k - 14));
    else if (k >= 18 && k < 22) v = W >> (8 * (k - 18));
    else if (k >= 22 && k < 26) v = H >> (8 * (k - 22));
    else if (k >= 26 && k < 28) v = 1 >> (8 * (k - 26));
    else if (k >= 28 && k < 30) v = 24 >> (8 * (k - 28));
    return 8'(v);
  endfunction
  task automatic pushRun();
    for (int k = 0; k < NB; k++) q.push_back(expByte(k));
  endtask
  task automatic waitDone(input string tag);
    int wt;
    wt = 0;
    while (!bus.isTransmitted && wt < 3000) begin
      @(negedge HCLK);
      wt++;
    end
    check(tag, 32'(wt < 3000), 1);
  endtask
  // UART: done pulse 10 cycles after each launch; memory: data valid only the cycle after a read
  always @(posedge HCLK) begin
    rdEnS = bus.mem_rd_en;
    addrS = bus.mem_rd_addr;
    #1;
    bus.mem_rd_data = rdEnS ? addrS[7:0] + 8'd100 : 8'hEE;
    uartDone = 1'b0;
    if (!HRESET) cnt = 0;
    else if (bus.TxD_start) cnt = 10;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) uartDone = 1'b1;
    end
  end
  always @(negedge HCLK) begin
    if (HRESET) begin
      if (bus.TxD_start) begin
        nLaunch++;
        check("tx_gap", 32'(prevTx), 0);
        check("tx_pending", 32'(q.size() > 0), 1);
        if (q.size() > 0) check("tx_byte", 32'(bus.transmitData), 32'(q.pop_front()));
      end
      prevTx = bus.TxD_start;
    end else prevTx = 1'b0;
  end
  initial begin
    int wt;
    bus.start = 1'b0;
    repeat (2) @(negedge HCLK);
    check("rst_txstart", 32'(bus.TxD_start), 0);
    check("rst_rden", 32'(bus.mem_rd_en), 0);
    check("rst_addr", 32'(bus.mem_rd_addr), 0);
    check("rst_data", 32'(bus.transmitData), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.isTransmitted), 0);
    HRESET = 1'b1;
    @(negedge HCLK);
    spurDone = 1'b1;
    @(negedge HCLK);
    spurDone = 1'b0;
    @(negedge HCLK);
    check("idle_spur_busy", 32'(bus.busy), 0);
    check("idle_spur_launch", 32'(nLaunch), 0);
    pushRun();
    bus.start = 1'b1;
    @(negedge HCLK);
    check("start_lat_n", 32'(bus.TxD_start), 0);
    check("start_busy", 32'(bus.busy), 1);
    @(negedge HCLK);
    check("start_lat_n1", 32'(bus.TxD_start), 1);
    wt = 0;
    while (!(bus.TxD_done && nLaunch == 54) && wt < 2000) begin
      @(negedge HCLK);
      wt++;
    end
    check("wait_hdr_end", 32'(wt < 2000), 1);
    @(negedge HCLK);
    check("fetch_m0_rden", 32'(bus.mem_rd_en), 0);
    @(negedge HCLK);
    check("fetch_m1_rden", 32'(bus.mem_rd_en), 1);
    check("fetch_m1_addr", 32'(bus.mem_rd_addr), 0);
    spurDone = 1'b1;
    @(negedge HCLK);
    spurDone = 1'b0;
    check("rdwait_m2_tx", 32'(bus.TxD_start), 0);
    check("rdwait_m2_rden", 32'(bus.mem_rd_en), 0);
    @(negedge HCLK);
    check("send_m3_tx", 32'(bus.TxD_start), 1);
    check("send_m3_data", 32'(bus.transmitData), 100);
    waitDone("run1_timeout");
    check("run1_count", 32'(nLaunch), NB);
    check("run1_queue", 32'(q.size()), 0);
    check("run1_busy", 32'(bus.busy), 0);
    repeat (5) @(negedge HCLK);
    check("hold_done", 32'(bus.isTransmitted), 1);
    check("hold_count", 32'(nLaunch), NB);
    bus.start = 1'b0;
    @(negedge HCLK);
    check("idle_clear", 32'(bus.isTransmitted), 0);
    check("idle_busy", 32'(bus.busy), 0);
    pushRun();
    bus.start = 1'b1;
    @(negedge HCLK);
    waitDone("run2_timeout");
    check("run2_count", 32'(nLaunch), 2 * NB);
    check("run2_queue", 32'(q.size()), 0);
    bus.start = 1'b0;
    repeat (2) @(negedge HCLK);
    pushRun();
    bus.start = 1'b1;
    wt = 0;
    while (nLaunch < 2 * NB + 61 && wt < 2000) begin
      @(negedge HCLK);
      wt++;
    end
    check("wait_byte60", 32'(wt < 2000), 1);
    HRESET = 1'b0;
    #1;
    check("mid_rst_txstart", 32'(bus.TxD_start), 0);
    check("mid_rst_rden", 32'(bus.mem_rd_en), 0);
    check("mid_rst_addr", 32'(bus.mem_rd_addr), 0);
    check("mid_rst_data", 32'(bus.transmitData), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.isTransmitted), 0);
    q.delete();
    bus.start = 1'b0;
    base = nLaunch;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b1;
    repeat (15) @(negedge HCLK);
    check("post_rst_quiet", 32'(nLaunch), 32'(base));
    check("post_rst_busy", 32'(bus.busy), 0);
    pushRun();
    bus.start = 1'b1;
    @(negedge HCLK);
    waitDone("run3_timeout");
    check("run3_count", 32'(nLaunch), 32'(base + NB));
    check("run3_queue", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
